tournament_chooser: RTL and testbench

Parametrised tournament chooser for the IF-stage branch predictor: a table of saturating counters that selects, per fetch slot, between the history-based (PHT) and per-address (BHT) direction predictors. Generalises the fixed 2-port, 2-bit chooser to N search ports, configurable counter width, and optional global-history XOR indexing. Adds a registered update stage with bypass, plus a table-clear sweep FSM after reset and on request. Sits beside the PHT/BHT cores in `IF/branch`; its `select_o` bits drive the per-slot direction mux.

---
 rtl/tournament_chooser.sv | 145 ++++++++++++++
 tb/tb_tournament_chooser.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tournament_chooser.sv
// rtl/tournament_chooser.sv - PHT/BHT tournament chooser with registered update, bypass and clear sweep
module tournament_chooser #(
  parameter int IDX_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int NUM_PORTS = 2,
  parameter int HIST_BITS = 0,
  localparam int HW       = (HIST_BITS > 0) ? HIST_BITS : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  output logic                      ready_o,
  input  logic [32*NUM_PORTS-1:0]   search_addr_i,
  input  logic [HW-1:0]             search_hist_i,
  output logic [NUM_PORTS-1:0]      select_o,
  input  logic                      corr_valid_i,
  input  logic [31:0]               corr_addr_i,
  input  logic [HW-1:0]             corr_hist_i,
  input  logic                      corr_pht_flag_i,
  input  logic                      corr_bht_flag_i,
  input  logic                      corr_branch_flag_i
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state, state_nxt;
  logic [IDX_BITS-1:0] sweep_idx, sweep_idx_nxt;
  logic [CTR_BITS-1:0] table_q [ENTRIES];

  logic                pend_v;
  logic [IDX_BITS-1:0] pend_idx;
  logic [CTR_BITS-1:0] pend_val;

  logic [IDX_BITS-1:0] search_idx [NUM_PORTS];
  logic [CTR_BITS-1:0] search_val [NUM_PORTS];

  logic [IDX_BITS-1:0] corr_idx;
  logic [CTR_BITS-1:0] corr_cur, corr_new;
  logic                pht_ok, bht_ok, corr_upd;

  logic                tbl_we;
  logic [IDX_BITS-1:0] tbl_widx;
  logic [CTR_BITS-1:0] tbl_wval;

  // Address bits outside the index window and history bits beyond IDX_BITS are not needed
  logic unused_bits;
  assign unused_bits = ^{search_addr_i, search_hist_i, corr_addr_i, corr_hist_i};

  // Table index: word-aligned PC bits XORed with zero-extended/truncated history
  function automatic logic [IDX_BITS-1:0] calc_idx(input logic [IDX_BITS-1:0] pc_bits,
                                                   input logic [HW-1:0] hist);
    logic [IDX_BITS-1:0] h;
    for (int i = 0; i < IDX_BITS; i++) begin
      h[i] = (i < HIST_BITS) ? hist[i % HW] : 1'b0;
    end
    return pc_bits ^ h;
  endfunction

  assign ready_o = (state == S_RUN);

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    assign search_idx[k] = calc_idx(search_addr_i[32*k+2 +: IDX_BITS], search_hist_i);
    assign search_val[k] = (pend_v && (pend_idx == search_idx[k])) ? pend_val
                                                                    : table_q[search_idx[k]];
    assign select_o[k]   = (state == S_RUN) && search_val[k][CTR_BITS-1];
  end

  assign corr_idx = calc_idx(corr_addr_i[IDX_BITS+1:2], corr_hist_i);
  assign corr_cur = (pend_v && (pend_idx == corr_idx)) ? pend_val : table_q[corr_idx];
  assign pht_ok   = (corr_pht_flag_i == corr_branch_flag_i);
  assign bht_ok   = (corr_bht_flag_i == corr_branch_flag_i);
  assign corr_upd = corr_valid_i && (pht_ok ^ bht_ok);

  // Saturating step toward PHT when only it was right, toward BHT when only it was right
  always_comb begin
    corr_new = corr_cur;
    if (pht_ok) begin
      if (corr_cur != CTR_MAX) corr_new = corr_cur + CTR_ONE;
    end else begin
      if (corr_cur != '0) corr_new = corr_cur - CTR_ONE;
    end
  end

  // Sweep/run sequencing; clear restarts the sweep from entry 0 in either state
  always_comb begin
    state_nxt     = state;
    sweep_idx_nxt = sweep_idx;
    case (state)
      S_INIT: begin
        if (clear_i) begin
          sweep_idx_nxt = '0;
        end else begin
          sweep_idx_nxt = sweep_idx + IDX_ONE;
          if (sweep_idx == '1) state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (clear_i) begin
          state_nxt     = S_INIT;
          sweep_idx_nxt = '0;
        end
      end
      default: begin
        state_nxt     = S_INIT;
        sweep_idx_nxt = '0;
      end
    endcase
  end

  // Control state and the pending-write register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      sweep_idx <= '0;
      pend_v    <= 1'b0;
      pend_idx  <= '0;
      pend_val  <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_idx_nxt;
      pend_v    <= (state == S_RUN) && !clear_i && corr_upd;
      if (corr_upd) begin
        pend_idx <= corr_idx;
        pend_val <= corr_new;
      end
    end
  end

  // Single write port: sweep entries while initialising, committed updates while running
  assign tbl_we   = !clear_i && ((state == S_INIT) || pend_v);
  assign tbl_widx = (state == S_INIT) ? sweep_idx : pend_idx;
  assign tbl_wval = (state == S_INIT) ? CTR_INIT : pend_val;

  // Counter table storage; contents are defined by the sweep rather than by reset
  always_ff @(posedge clk) begin
    if (tbl_we) table_q[tbl_widx] <= tbl_wval;
  end

endmodule

// File: tb/tb_tournament_chooser.sv
// tb/tb_tournament_chooser.sv - directed vector bench for tournament_chooser
module tb_tournament_chooser;

  logic        clk;
  logic        rst;
  logic        clear_i;
  logic        ready_o;
  logic [31:0] a0, a1;
  logic [3:0]  sh;
  logic [1:0]  select_o;
  logic        corr_valid_i;
  logic [31:0] corr_addr_i;
  logic [3:0]  corr_hist_i;
  logic        corr_pht_flag_i, corr_bht_flag_i, corr_branch_flag_i;

  int n_chk;
  int n_fail;

  tournament_chooser #(
    .IDX_BITS (5),
    .CTR_BITS (2),
    .NUM_PORTS(2),
    .HIST_BITS(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .clear_i           (clear_i),
    .ready_o           (ready_o),
    .search_addr_i     ({a1, a0}),
    .search_hist_i     (sh),
    .select_o          (select_o),
    .corr_valid_i      (corr_valid_i),
    .corr_addr_i       (corr_addr_i),
    .corr_hist_i       (corr_hist_i),
    .corr_pht_flag_i   (corr_pht_flag_i),
    .corr_bht_flag_i   (corr_bht_flag_i),
    .corr_branch_flag_i(corr_branch_flag_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [31:0] ca;
    logic [3:0]  ch;
    logic        pf, bf, br;
    logic [31:0] a0, a1;
    logic [3:0]  sh;
    logic [1:0]  esel;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic cv, input logic [31:0] ca, input logic [3:0] ch,
                      input logic pf, input logic bf, input logic br,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic [3:0] h, input logic [1:0] esel);
    vec_t v;
    v.cv = cv; v.ca = ca; v.ch = ch; v.pf = pf; v.bf = bf; v.br = br;
    v.a0 = p0; v.a1 = p1; v.sh = h; v.esel = esel;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_corr(input logic cv, input logic [31:0] ca, input logic [3:0] ch,
                          input logic pf, input logic bf, input logic br);
    corr_valid_i = cv; corr_addr_i = ca; corr_hist_i = ch;
    corr_pht_flag_i = pf; corr_bht_flag_i = bf; corr_branch_flag_i = br;
  endtask

  // Counts edges until ready_o rises, bounded
  task automatic count_sweep(input string name, input int exp_edges);
    int n;
    n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, exp_edges);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    clear_i = 1'b0;
    a0 = 32'h100; a1 = 32'h104; sh = 4'h0;
    set_corr(1'b1, 32'h100, 4'h0, 1'b1, 1'b0, 1'b1);

    #2;
    check("rst_ready", ready_o, 0);
    check("rst_select", select_o, 0);
    repeat (2) @(posedge clk);

    // Reset release: 32-entry sweep, corr traffic ignored throughout
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("sweep_ready_%0d", i), ready_o, 0);
      check($sformatf("sweep_sel_%0d", i), select_o, 0);
      @(posedge clk);
      #1;
    end
    set_corr(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("sweep_done_ready", ready_o, 1);
    check("sweep_dropped_upd", select_o, 0);

    for (int j = 0; j < 32; j++) begin
      a0 = 32'(j) << 2;
      a1 = 32'(j) << 2;
      @(negedge clk);
      check($sformatf("init_entry_%0d", j), select_o, 0);
    end
    tick();

    //    cv  corr_addr  ch   pf    bf    br    port0     port1     sh    sel{p1,p0}
    addv(0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h104, 4'h0, 2'b00);
    addv(1, 32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h100, 4'h0, 2'b00);
    addv(1, 32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h104, 4'h0, 2'b01);
    addv(1, 32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h104, 32'h100, 4'h0, 2'b10);
    addv(0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h100, 4'h0, 2'b11);
    addv(0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h100, 4'h0, 2'b11);
    addv(1, 32'h104, 4'h0, 1'b0, 1'b0, 1'b1, 32'h104, 32'h104, 4'h0, 2'b00);
    addv(1, 32'h104, 4'h0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h104, 4'h0, 2'b00);
    addv(1, 32'h100, 4'h0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h104, 4'h0, 2'b00);
    addv(0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h100, 4'h0, 2'b11);
    addv(1, 32'h100, 4'h0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h104, 4'h0, 2'b01);
    addv(0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h100, 4'h0, 2'b00);
    addv(1, 32'h108, 4'h0, 1'b1, 1'b0, 1'b1, 32'h10C, 32'h10C, 4'h0, 2'b00);
    addv(0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b0, 32'h10C, 32'h108, 4'h0, 2'b10);
    addv(1, 32'h40,  4'h3, 1'b1, 1'b0, 1'b1, 32'h4C,  32'h4C,  4'h0, 2'b00);
    addv(0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b0, 32'h4C,  32'h4C,  4'h0, 2'b11);
    addv(0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b0, 32'h40,  32'h4C,  4'h0, 2'b10);
    addv(0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b0, 32'h40,  32'h4C,  4'h3, 2'b01);
    addv(1, 32'h104, 4'h0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h104, 4'h0, 2'b00);
    addv(1, 32'h104, 4'h0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h104, 4'h0, 2'b00);
    addv(1, 32'h104, 4'h0, 1'b1, 1'b0, 1'b1, 32'h104, 32'h104, 4'h0, 2'b00);
    addv(1, 32'h104, 4'h0, 1'b1, 1'b0, 1'b1, 32'h104, 32'h104, 4'h0, 2'b00);
    addv(0, 32'h104, 4'h0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h104, 4'h0, 2'b11);
    addv(0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b0, 32'h104, 32'h104, 4'h0, 2'b11);
    addv(1, 32'h104, 4'h0, 1'b0, 1'b1, 1'b0, 32'h104, 32'h104, 4'h0, 2'b11);
    addv(1, 32'h104, 4'h0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h104, 4'h0, 2'b11);
    addv(0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b0, 32'h104, 32'h104, 4'h0, 2'b11);

    foreach (vq[i]) begin
      set_corr(vq[i].cv, vq[i].ca, vq[i].ch, vq[i].pf, vq[i].bf, vq[i].br);
      a0 = vq[i].a0;
      a1 = vq[i].a1;
      sh = vq[i].sh;
      @(negedge clk);
      check($sformatf("vec%0d_sel", i), select_o, vq[i].esel);
      check($sformatf("vec%0d_ready", i), ready_o, 1);
      @(posedge clk);
      #1;
    end

    // Clear in RUN with an update still pending
    set_corr(1'b1, 32'h108, 4'h0, 1'b1, 1'b0, 1'b1);
    a0 = 32'h108; a1 = 32'h100; sh = 4'h0;
    @(negedge clk);
    check("clr_pre_sel", select_o, 2'b01);
    tick();
    set_corr(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    clear_i = 1'b1;
    a0 = 32'h108; a1 = 32'h108;
    @(negedge clk);
    check("clr_bypass_sel", select_o, 2'b11);
    tick();
    clear_i = 1'b0;
    check("clr_ready_drop", ready_o, 0);
    check("clr_sel_drop", select_o, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("clr_sweep_ready_%0d", i), ready_o, 0);
    end

    // Clear again while sweeping: restart from entry 0
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    count_sweep("clr_restart_edges", 32);

    a0 = 32'h40; a1 = 32'h104; sh = 4'h3;
    @(negedge clk);
    check("clr_entries_init", select_o, 0);
    tick();
    set_corr(1'b1, 32'h108, 4'h0, 1'b1, 1'b0, 1'b1);
    a0 = 32'h100; a1 = 32'h108; sh = 4'h0;
    tick();
    set_corr(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("clr_post_update", select_o, 2'b10);
    tick();

    // Async reset in the middle of a sweep
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    repeat (10) tick();
    #2;
    rst = 1'b0;
    #1;
    check("midsweep_rst_ready", ready_o, 0);
    @(negedge clk);
    rst = 1'b1;
    count_sweep("midsweep_rst_edges", 32);

    a0 = 32'h40; a1 = 32'h108; sh = 4'h3;
    @(negedge clk);
    check("rst_entries_init", select_o, 0);
    tick();
    set_corr(1'b1, 32'h4C, 4'h0, 1'b1, 1'b0, 1'b1);
    tick();
    set_corr(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_post_update", select_o, 2'b01);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
